// File: rtl/stack_matrix_driver_if.sv
// Signal bundle between the stacker game FSM / LED board (master) and the matrix driver (slave).
// Plain wires only; the driver applies no flow control and accepts a write or clear on every cycle.
interface stack_matrix_driver_if;
    logic       wr_en;
    logic [2:0] wr_row;
    logic [7:0] wr_data;
    logic       clr;
    logic [2:0] rd_row;
    logic [7:0] rd_data;
    logic [7:0] row_sel_n;
    logic [7:0] col_data;
    logic       frame_start;

    modport master (
        output wr_en, wr_row, wr_data, clr, rd_row,
        input  rd_data, row_sel_n, col_data, frame_start
    );

    modport slave (
        input  wr_en, wr_row, wr_data, clr, rd_row,
        output rd_data, row_sel_n, col_data, frame_start
    );
endinterface

// File: rtl/stack_matrix_driver.sv
// 8x8 playfield store plus row-multiplexed LED scan; writes land in 1 cycle, readback is 1 cycle.
// No backpressure: writes/clears are accepted every cycle, display outputs are registered.
module stack_matrix_driver #(
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input logic                  clk,
    input logic                  reset,
    stack_matrix_driver_if.slave mx
);
    localparam logic [0:0]  BLANK      = 1'b0;
    localparam logic [0:0]  DRIVE      = 1'b1;
    localparam logic [15:0] DIV_LAST   = 16'(SCAN_DIV - 1);
    localparam logic [15:0] BLANK_LAST = 16'(BLANK_CYCLES - 1);

    logic [7:0]  mem [8];
    logic [15:0] div;
    logic [2:0]  ptr;
    logic [0:0]  state;
    logic [7:0]  snap;
    logic [7:0]  rd_q;
    logic [7:0]  row_q;
    logic [7:0]  col_q;
    logic        frame_q;

    logic        div_wrap;
    logic        to_drive;
    logic        to_blank;
    logic [0:0]  state_nxt;
    logic [7:0]  snap_nxt;

    always_comb begin
        div_wrap  = (div == DIV_LAST);
        to_drive  = (state == BLANK) && (div == BLANK_LAST);
        to_blank  = (state == DRIVE) && div_wrap;
        state_nxt = state;
        if (to_drive)
            state_nxt = DRIVE;
        else if (to_blank)
            state_nxt = BLANK;
        // Snapshot is frozen for the slot; only a clear may disturb it mid-slot.
        snap_nxt = snap;
        if (mx.clr)
            snap_nxt = 8'h00;
        else if (to_drive)
            snap_nxt = (mx.wr_en && (mx.wr_row == ptr)) ? mx.wr_data : mem[ptr];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div     <= '0;
            ptr     <= '0;
            state   <= BLANK;
            snap    <= '0;
            rd_q    <= '0;
            row_q   <= 8'hFF;
            col_q   <= 8'h00;
            frame_q <= 1'b0;
            for (int i = 0; i < 8; i++)
                mem[i] <= '0;
        end else begin
            div     <= div_wrap ? 16'd0 : div + 16'd1;
            ptr     <= div_wrap ? ptr + 3'd1 : ptr;
            state   <= state_nxt;
            snap    <= snap_nxt;
            rd_q    <= mem[mx.rd_row];
            row_q   <= (state_nxt == DRIVE) ? ~(8'h01 << ptr) : 8'hFF;
            col_q   <= (state_nxt == DRIVE) ? snap_nxt : 8'h00;
            // ptr only reaches 0 by wrapping here, so the post-reset slot never pulses.
            frame_q <= div_wrap && (ptr == 3'd7);
            if (mx.clr) begin
                for (int i = 0; i < 8; i++)
                    mem[i] <= '0;
            end else if (mx.wr_en) begin
                mem[mx.wr_row] <= mx.wr_data;
            end
        end
    end

    assign mx.rd_data     = rd_q;
    assign mx.row_sel_n   = row_q;
    assign mx.col_data    = col_q;
    assign mx.frame_start = frame_q;
endmodule

// File: tb/tb_stack_matrix_driver.sv
// Directed and randomised checks of stack_matrix_driver at SCAN_DIV=8, BLANK_CYCLES=2.
module tb_stack_matrix_driver;
    localparam int SD = 8;
    localparam int BC = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    stack_matrix_driver_if mx();

    stack_matrix_driver #(.SCAN_DIV(SD), .BLANK_CYCLES(BC)) dut (
        .clk   (clk),
        .reset (reset),
        .mx    (mx)
    );

    int         n_checks = 0;
    int         n_errors = 0;
    int         t = 0;
    logic [7:0] m_mem [8];
    logic [7:0] m_snap = 8'h00;
    logic [7:0] m_rd = 8'h00;
    logic [7:0] sel_tbl [11];
    logic [7:0] sel_seen [11];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0d)", tag, got, exp, t);
        end
    endtask

    // One clock edge: advance the reference model with the inputs seen at the edge, then compare.
    task automatic step();
        int p;
        int r;
        logic [7:0] e_sel;
        logic [7:0] e_col;
        @(posedge clk);
        p = t % SD;
        r = (t / SD) % 8;
        if (reset) begin
            t = 0;
            m_snap = 8'h00;
            m_rd = 8'h00;
            for (int i = 0; i < 8; i++) m_mem[i] = 8'h00;
        end else begin
            m_rd = m_mem[mx.rd_row];
            if (p == BC - 1)
                m_snap = mx.clr ? 8'h00 : ((mx.wr_en && mx.wr_row == 3'(r)) ? mx.wr_data : m_mem[r]);
            else if (mx.clr)
                m_snap = 8'h00;
            if (mx.clr)
                for (int i = 0; i < 8; i++) m_mem[i] = 8'h00;
            else if (mx.wr_en)
                m_mem[mx.wr_row] = mx.wr_data;
            t++;
        end
        #1;
        p = t % SD;
        r = (t / SD) % 8;
        e_sel = (p < BC) ? 8'hFF : ~(8'h01 << r);
        e_col = (p < BC) ? 8'h00 : m_snap;
        check("row_sel_n", mx.row_sel_n, e_sel);
        check("col_data", mx.col_data, e_col);
        check("frame_start", mx.frame_start, (t % 64 == 0 && t > 0) ? 1 : 0);
        check("rd_data", mx.rd_data, m_rd);
        check("onehot", ($countones(~mx.row_sel_n) <= 1) ? 1 : 0, 1);
    endtask

    task automatic run_to(input int target);
        for (int k = 0; k < 200 && (t % 64) != target; k++) step();
        check("run_to", t % 64, target);
    endtask

    initial begin
        int fs_cnt;
        int fs_at;
        int last_fs;
        for (int i = 0; i < 8; i++) m_mem[i] = 8'h00;
        sel_tbl = '{8'hFF, 8'hFF, 8'hFE, 8'hFE, 8'hFE, 8'hFE, 8'hFE, 8'hFE, 8'hFF, 8'hFF, 8'hFD};
        reset = 1'b1;
        mx.wr_en = 1'b0; mx.wr_row = 3'd0; mx.wr_data = 8'h00; mx.clr = 1'b0; mx.rd_row = 3'd0;

        // Reset and first frame timing
        repeat (3) step();
        check("rst_sel", mx.row_sel_n, 8'hFF);
        check("rst_col", mx.col_data, 8'h00);
        check("rst_fs", mx.frame_start, 0);
        check("rst_rd", mx.rd_data, 8'h00);
        reset = 1'b0;
        sel_seen[0] = mx.row_sel_n;
        fs_cnt = 0;
        fs_at = -1;
        for (int k = 1; k <= 70; k++) begin
            step();
            if (k <= 10) sel_seen[k] = mx.row_sel_n;
            if (mx.frame_start) begin
                fs_cnt++;
                fs_at = k;
            end
        end
        for (int k = 0; k <= 10; k++) check("scan_seq", sel_seen[k], sel_tbl[k]);
        check("fs_count", fs_cnt, 1);
        check("fs_first", fs_at, 64);

        // Single write to row 3, readback latency and display slot
        mx.wr_en = 1'b1; mx.wr_row = 3'd3; mx.wr_data = 8'hE0; mx.rd_row = 3'd3;
        step();
        mx.wr_en = 1'b0;
        check("rd_lat1", mx.rd_data, 8'h00);
        step();
        check("rd_lat2", mx.rd_data, 8'hE0);
        for (int k = 0; k < 64; k++) begin
            step();
            if (mx.row_sel_n == 8'hF7) check("row3_col", mx.col_data, 8'hE0);
            else if (mx.row_sel_n != 8'hFF) check("other_col", mx.col_data, 8'h00);
        end

        // Mid-DRIVE write is deferred; write on the BLANK->DRIVE edge bypasses
        run_to(4);
        mx.wr_en = 1'b1; mx.wr_row = 3'd0; mx.wr_data = 8'h1C;
        step();
        mx.wr_en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("row0_old", mx.col_data, 8'h00);
            step();
        end
        run_to(2);
        check("row0_new", mx.col_data, 8'h1C);
        mx.wr_en = 1'b1; mx.wr_data = 8'h00;
        step();
        mx.wr_en = 1'b0;
        check("row0_hold", mx.col_data, 8'h1C);
        run_to(1);
        check("pre_bypass", mx.col_data, 8'h00);
        mx.wr_en = 1'b1; mx.wr_data = 8'h1C;
        step();
        mx.wr_en = 1'b0;
        check("bypass_col", mx.col_data, 8'h1C);
        check("bypass_sel", mx.row_sel_n, 8'hFE);

        // Clear beats a same-cycle write
        for (int i = 0; i < 8; i++) begin
            mx.wr_en = 1'b1; mx.wr_row = 3'(i); mx.wr_data = 8'hFF;
            step();
        end
        mx.wr_en = 1'b0;
        run_to(0);
        run_to(20);
        check("pre_clr_col", mx.col_data, 8'hFF);
        mx.clr = 1'b1; mx.wr_en = 1'b1; mx.wr_row = 3'd5; mx.wr_data = 8'hAA;
        step();
        mx.clr = 1'b0; mx.wr_en = 1'b0;
        check("clr_col", mx.col_data, 8'h00);
        for (int i = 0; i < 8; i++) begin
            mx.rd_row = 3'(i);
            step();
            check("clr_rd", mx.rd_data, 8'h00);
        end
        for (int k = 0; k < 16; k++) begin
            step();
            check("clr_col_hold", mx.col_data, 8'h00);
        end

        // Reset in the middle of row 5's DRIVE phase
        run_to(44);
        mx.wr_en = 1'b1; mx.wr_row = 3'd6; mx.wr_data = 8'h3C;
        step();
        mx.wr_en = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rst_mid_sel", mx.row_sel_n, 8'hFF);
        step();
        step();
        check("rst_mid_fe", mx.row_sel_n, 8'hFE);
        mx.rd_row = 3'd6;
        step();
        check("rst_mid_rd", mx.rd_data, 8'h00);

        // Three frames of random traffic against the model
        last_fs = -1;
        for (int k = 0; k < 192; k++) begin
            mx.wr_en   = ($urandom_range(0, 3) == 0);
            mx.wr_row  = 3'($urandom_range(0, 7));
            mx.wr_data = 8'($urandom_range(0, 255));
            mx.clr     = ($urandom_range(0, 63) == 0);
            mx.rd_row  = 3'($urandom_range(0, 7));
            step();
            if (mx.frame_start) begin
                if (last_fs >= 0) check("fs_period", k - last_fs, 64);
                last_fs = k;
            end
        end
        mx.wr_en = 1'b0; mx.clr = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
